// File: rtl/age_rs.sv
// Age-ordered reservation station: dispatch to the lowest free slot, wake operands from broadcast channels, and issue the oldest ready entry.
// The output register loads one cycle after an entry becomes ready and holds while out_valid && !out_ready.
module age_rs #(
    parameter int DEPTH = 8,
    parameter int NBC   = 5,
    parameter int TAG_W = 5,
    parameter int XLEN  = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [6:0]              in_type,
    input  logic [3:0]              in_op,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic                    in_need1,
    input  logic                    in_need2,
    input  logic [TAG_W-1:0]        in_dep1,
    input  logic [TAG_W-1:0]        in_dep2,
    input  logic [XLEN-1:0]         in_val1,
    input  logic [XLEN-1:0]         in_val2,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [XLEN-1:0]         in_imm,
    input  logic [NBC-1:0]          bc_valid,
    input  logic [NBC*TAG_W-1:0]    bc_tag,
    input  logic [NBC*XLEN-1:0]     bc_value,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [TAG_W-1:0]        out_tag,
    output logic [6:0]              out_type,
    output logic [3:0]              out_op,
    output logic [XLEN-1:0]         out_v1,
    output logic [XLEN-1:0]         out_v2,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [6:0] OPC_REG = 7'b0110011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;

    logic [DEPTH-1:0] r_busy;
    logic [TAG_W-1:0] r_dep1 [DEPTH];
    logic [TAG_W-1:0] r_dep2 [DEPTH];
    logic [TAG_W-1:0] r_tag  [DEPTH];
    logic [6:0]       r_type [DEPTH];
    logic [3:0]       r_op   [DEPTH];
    logic [XLEN-1:0]  r_v1   [DEPTH];
    logic [XLEN-1:0]  r_v2   [DEPTH];
    logic [XLEN-1:0]  r_imm  [DEPTH];
    // r_older[j][i] set means entry j was dispatched before entry i
    logic [DEPTH-1:0] r_older [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_out_valid;
    logic [TAG_W-1:0] r_out_tag;
    logic [6:0]       r_out_type;
    logic [3:0]       r_out_op;
    logic [XLEN-1:0]  r_out_v1;
    logic [XLEN-1:0]  r_out_v2;

    logic [XLEN:0]    w_wk1 [DEPTH];
    logic [XLEN:0]    w_wk2 [DEPTH];
    logic [XLEN:0]    w_cap1;
    logic [XLEN:0]    w_cap2;
    logic [DEPTH-1:0] w_ready;
    logic [DEPTH-1:0] w_oldest;
    logic             w_sel_vld;
    logic [IW-1:0]    w_sel_idx;
    logic [IW-1:0]    w_free_idx;
    logic             w_disp;
    logic             w_issue;

    // {hit, value}; scanning downward lets the lowest matching channel win
    function automatic logic [XLEN:0] snoop(
        input logic [TAG_W-1:0]     dep,
        input logic [NBC-1:0]       vld,
        input logic [NBC*TAG_W-1:0] tags,
        input logic [NBC*XLEN-1:0]  vals
    );
        logic [XLEN:0] res;
        res = '0;
        for (int k = NBC - 1; k >= 0; k--) begin
            if (vld[k] && dep != '0 && tags[k*TAG_W +: TAG_W] == dep)
                res = {1'b1, vals[k*XLEN +: XLEN]};
        end
        return res;
    endfunction

    assign in_ready = r_count < LP_DEPTH;
    assign w_disp   = in_valid && in_ready && rdy_in && !flush_in;
    assign w_issue  = rdy_in && !flush_in && (!r_out_valid || out_ready) && w_sel_vld;

    always_comb begin
        w_cap1     = snoop(in_dep1, bc_valid, bc_tag, bc_value);
        w_cap2     = snoop(in_dep2, bc_valid, bc_tag, bc_value);
        w_free_idx = '0;
        w_sel_vld  = 1'b0;
        w_sel_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wk1[i]   = snoop(r_dep1[i], bc_valid, bc_tag, bc_value);
            w_wk2[i]   = snoop(r_dep2[i], bc_valid, bc_tag, bc_value);
            w_ready[i] = r_busy[i] && r_dep1[i] == '0 && r_dep2[i] == '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_oldest[i] = w_ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && w_ready[j] && r_older[j][i])
                    w_oldest[i] = 1'b0;
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i])
                w_free_idx = IW'(i);
            if (w_oldest[i]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_busy      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_type  <= '0;
            r_out_op    <= '0;
            r_out_v1    <= '0;
            r_out_v2    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dep1[i] <= '0;
                r_dep2[i] <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                r_busy      <= '0;
                r_count     <= '0;
                r_out_valid <= 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_busy[i] && w_wk1[i][XLEN]) r_dep1[i] <= '0;
                    if (r_busy[i] && w_wk2[i][XLEN]) r_dep2[i] <= '0;
                end
                if (w_issue) begin
                    r_busy[w_sel_idx] <= 1'b0;
                    r_out_valid       <= 1'b1;
                    r_out_tag         <= r_tag[w_sel_idx];
                    r_out_type        <= r_type[w_sel_idx];
                    r_out_op          <= r_op[w_sel_idx];
                    r_out_v1          <= r_v1[w_sel_idx];
                    r_out_v2          <= (r_type[w_sel_idx] == OPC_REG || r_type[w_sel_idx] == OPC_BR)
                                         ? r_v2[w_sel_idx] : r_imm[w_sel_idx];
                end else if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
                if (w_disp) begin
                    r_busy[w_free_idx] <= 1'b1;
                    r_dep1[w_free_idx] <= (!in_need1 || w_cap1[XLEN]) ? '0 : in_dep1;
                    r_dep2[w_free_idx] <= (!in_need2 || w_cap2[XLEN]) ? '0 : in_dep2;
                end
                r_count <= r_count + CW'(w_disp) - CW'(w_issue);
            end
        end
    end

    // Payload and age state need no reset: busy gates every use of them
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_busy[i] && w_wk1[i][XLEN]) r_v1[i] <= w_wk1[i][XLEN-1:0];
                if (r_busy[i] && w_wk2[i][XLEN]) r_v2[i] <= w_wk2[i][XLEN-1:0];
            end
            if (w_disp) begin
                r_tag[w_free_idx]  <= in_tag;
                r_type[w_free_idx] <= in_type;
                r_op[w_free_idx]   <= in_op;
                r_imm[w_free_idx]  <= in_imm;
                r_v1[w_free_idx]   <= !in_need1 ? in_pc : (w_cap1[XLEN] ? w_cap1[XLEN-1:0] : in_val1);
                r_v2[w_free_idx]   <= !in_need2 ? '0    : (w_cap2[XLEN] ? w_cap2[XLEN-1:0] : in_val2);
                for (int j = 0; j < DEPTH; j++) begin
                    r_older[w_free_idx][j] <= 1'b0;
                    r_older[j][w_free_idx] <= r_busy[j];
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_tag   = r_out_tag;
    assign out_type  = r_out_type;
    assign out_op    = r_out_op;
    assign out_v1    = r_out_v1;
    assign out_v2    = r_out_v2;
    assign count     = r_count;

endmodule
